rv32_mem_arbiter: RTL and testbench

Single-port memory arbiter for the RV32I pipeline: shares one unified instruction/data memory port between the IF stage (fetch) and the MEM stage (load/store). Grants one transaction at a time, holds it until the memory acknowledges, returns read data to the winning requester, and drives per-stage stall signals into the pipeline hazard logic. Data accesses have priority, and a bounded-burst counter guarantees fetch progress.

---
 rtl/rv32_mem_pkg.sv | 11 +
 rtl/rv32_mem_arbiter_if.sv | 47 ++++
 rtl/rv32_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32I unified-memory arbiter.
package rv32_mem_pkg;
    localparam int              BE_W    = 4;
    localparam logic [BE_W-1:0] BE_FULL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY_I,
        ST_BUSY_D
    } arb_state_e;
endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Fetch, data and memory-port signal bundle; master is the arbiter, slave is its environment.
interface rv32_mem_arbiter_if
    import rv32_mem_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_valid;
    logic            if_stall;

    logic            dm_req;
    logic            dm_we;
    logic [BE_W-1:0] dm_be;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_valid;
    logic            dm_stall;

    logic            mem_req;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_valid, if_stall,
        output dm_rdata, dm_valid, dm_stall,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_valid, if_stall,
        input  dm_rdata, dm_valid, dm_stall,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Shares one memory port between fetch and load/store; data has priority, with a
// bounded data-burst counter that forces a pending fetch through.
//
// state     | meaning
// ST_IDLE   | no transaction; arbitrate, ignoring a port whose valid is pulsing
// ST_BUSY_I | fetch latched onto mem_*, waiting for mem_ack
// ST_BUSY_D | load/store latched onto mem_*, waiting for mem_ack
module rv32_mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rv32_mem_arbiter_if.master  bus
);
    localparam int             CNT_W     = $clog2(MAX_D_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_D_BURST);

    arb_state_e      state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [BE_W-1:0] mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            dm_valid_q, dm_valid_d;

    logic if_ok, dm_ok, fetch_first;

    // A port whose completion is pulsing this cycle is still holding its old request.
    assign if_ok       = bus.if_req && !if_valid_q;
    assign dm_ok       = bus.dm_req && !dm_valid_q;
    assign fetch_first = if_ok && (!dm_ok || (burst_q == BURST_MAX));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            burst_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fetch_first) begin
                    state_d    = ST_BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = BE_FULL;
                    mem_addr_d = bus.if_addr;
                    burst_d    = '0;
                end else if (dm_ok) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_be_d    = bus.dm_we ? bus.dm_be : BE_FULL;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    if (!bus.if_req)
                        burst_d = '0;
                    else if (burst_q != BURST_MAX)
                        burst_d = burst_q + CNT_W'(1);
                end
            end
            ST_BUSY_I: begin
                if (bus.mem_ack) begin
                    if_rdata_d = bus.mem_rdata;
                    if_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_BUSY_D: begin
                if (bus.mem_ack) begin
                    if (!mem_we_q)
                        dm_rdata_d = bus.mem_rdata;
                    dm_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_stall  = bus.if_req && !if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.dm_stall  = bus.dm_req && !dm_valid_q;
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: inputs change and outputs are sampled 1ns after each rising edge.
module tb_rv32_mem_arbiter;
    logic clk_i;
    logic rst_ni;
    int   vec_cnt;
    int   err_cnt;

    rv32_mem_arbiter_if #(.XLEN(32)) bus ();

    rv32_mem_arbiter #(.XLEN(32), .MAX_D_BURST(4)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vec_cnt       = 0;
        err_cnt       = 0;
        rst_ni        = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_0010;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_be     = 4'h0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // Reset held with a fetch pending, then a zero-wait fetch.
        repeat (3) tick();
        check_vec("rst_mem_req",  {31'd0, bus.mem_req},  32'd0);
        check_vec("rst_mem_we",   {31'd0, bus.mem_we},   32'd0);
        check_vec("rst_mem_be",   {28'd0, bus.mem_be},   32'd0);
        check_vec("rst_mem_addr", bus.mem_addr,          32'd0);
        check_vec("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check_vec("rst_if_rdata", bus.if_rdata,          32'd0);
        check_vec("rst_dm_rdata", bus.dm_rdata,          32'd0);
        rst_ni = 1'b1;
        tick();
        check_vec("f1_mem_req",  {31'd0, bus.mem_req}, 32'd1);
        check_vec("f1_mem_addr", bus.mem_addr,         32'h10);
        check_vec("f1_mem_be",   {28'd0, bus.mem_be},  32'hF);
        check_vec("f1_if_stall", {31'd0, bus.if_stall}, 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        tick();
        check_vec("f1_if_valid", {31'd0, bus.if_valid}, 32'd1);
        check_vec("f1_if_rdata", bus.if_rdata,          32'h13);
        check_vec("f1_if_stall", {31'd0, bus.if_stall}, 32'd0);
        check_vec("f1_req_drop", {31'd0, bus.mem_req},  32'd0);
        bus.if_req  = 1'b0;
        bus.mem_ack = 1'b0;
        tick();
        check_vec("f1_valid_end", {31'd0, bus.if_valid}, 32'd0);

        // Simultaneous fetch and load: data first, fetch in the dm_valid cycle.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0020;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h0000_0100;
        tick();
        check_vec("pr_d_addr", bus.mem_addr,        32'h100);
        check_vec("pr_d_we",   {31'd0, bus.mem_we}, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_0001;
        tick();
        check_vec("pr_dm_valid", {31'd0, bus.dm_valid}, 32'd1);
        check_vec("pr_dm_rdata", bus.dm_rdata,          32'hCAFE_0001);
        check_vec("pr_dm_stall", {31'd0, bus.dm_stall}, 32'd0);
        check_vec("pr_if_stall", {31'd0, bus.if_stall}, 32'd1);
        bus.dm_req  = 1'b0;
        bus.mem_ack = 1'b0;
        tick();
        check_vec("pr_f_req",  {31'd0, bus.mem_req}, 32'd1);
        check_vec("pr_f_addr", bus.mem_addr,         32'h20);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0093;
        tick();
        check_vec("pr_if_rdata", bus.if_rdata, 32'h93);
        bus.if_req  = 1'b0;
        bus.mem_ack = 1'b0;
        tick();

        // Store with three wait cycles; inputs change under it and must be ignored.
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_be    = 4'b0011;
        bus.dm_addr  = 32'h0000_0200;
        bus.dm_wdata = 32'hDEAD_BEEF;
        tick();
        bus.dm_addr  = 32'h0000_0999;
        bus.dm_wdata = 32'h0;
        bus.dm_be    = 4'hF;
        for (int w = 0; w < 3; w++) begin
            check_vec("st_req",   {31'd0, bus.mem_req},  32'd1);
            check_vec("st_we",    {31'd0, bus.mem_we},   32'd1);
            check_vec("st_be",    {28'd0, bus.mem_be},   32'h3);
            check_vec("st_addr",  bus.mem_addr,          32'h200);
            check_vec("st_wdata", bus.mem_wdata,         32'hDEAD_BEEF);
            check_vec("st_stall", {31'd0, bus.dm_stall}, 32'd1);
            tick();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        tick();
        check_vec("st_dm_valid", {31'd0, bus.dm_valid}, 32'd1);
        check_vec("st_dm_rdata", bus.dm_rdata,          32'hCAFE_0001);
        bus.dm_req  = 1'b0;
        bus.dm_we   = 1'b0;
        bus.mem_ack = 1'b0;
        tick();

        // Spurious ack while idle.
        bus.mem_ack = 1'b1;
        repeat (2) begin
            tick();
            check_vec("sp_if_valid", {31'd0, bus.if_valid}, 32'd0);
            check_vec("sp_dm_valid", {31'd0, bus.dm_valid}, 32'd0);
            check_vec("sp_mem_req",  {31'd0, bus.mem_req},  32'd0);
        end
        bus.mem_ack = 1'b0;

        // Four data grants made with a fetch pending saturate the burst counter.
        bus.if_addr = 32'h0000_0040;
        bus.dm_addr = 32'h0000_0300;
        for (int i = 0; i < 4; i++) begin
            bus.if_req = 1'b1;
            bus.dm_req = 1'b1;
            tick();
            check_vec("bu_d_addr", bus.mem_addr, 32'h300);
            bus.if_req    = 1'b0;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'(i + 1);
            tick();
            check_vec("bu_dm_rdata", bus.dm_rdata, 32'(i + 1));
            bus.dm_req  = 1'b0;
            bus.mem_ack = 1'b0;
            tick();
        end
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        tick();
        check_vec("bu_f_wins", bus.mem_addr, 32'h40);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0073;
        tick();
        check_vec("bu_if_valid", {31'd0, bus.if_valid}, 32'd1);
        bus.if_req  = 1'b0;
        bus.mem_ack = 1'b0;
        tick();
        check_vec("bu_d_after_f", bus.mem_addr, 32'h300);
        bus.mem_ack = 1'b1;
        tick();
        bus.dm_req  = 1'b0;
        bus.mem_ack = 1'b0;
        tick();
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        tick();
        check_vec("bu_cnt_cleared", bus.mem_addr, 32'h300);
        bus.if_req  = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        bus.dm_req  = 1'b0;
        bus.mem_ack = 1'b0;
        tick();

        // Reset during an unacknowledged load, then re-arbitration of the held request.
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h0000_0400;
        tick();
        check_vec("rb_req", {31'd0, bus.mem_req}, 32'd1);
        tick();
        rst_ni = 1'b0;
        #1;
        check_vec("rb_async_drop", {31'd0, bus.mem_req}, 32'd0);
        tick();
        check_vec("rb_no_valid", {31'd0, bus.dm_valid}, 32'd0);
        rst_ni = 1'b1;
        tick();
        check_vec("rb_regrant", bus.mem_addr,         32'h400);
        check_vec("rb_req2",    {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        tick();
        check_vec("rb_dm_rdata", bus.dm_rdata, 32'h1234_5678);
        bus.dm_req  = 1'b0;
        bus.mem_ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
